// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt acknowledge sequencer: FSM encoding,
// controller register selects and vector id width.
package intr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUAL    = 3'd1,
        ST_ACK     = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPT    = 3'd4,
        ST_SERVICE = 3'd5,
        ST_SWRD    = 3'd6
    } state_e;

    localparam logic [1:0] SEL_VEC = 2'b00;
    localparam logic [1:0] SEL_IRR = 2'b01;
    localparam logic [1:0] SEL_IMR = 2'b10;
    localparam logic [1:0] SEL_ISR = 2'b11;

    localparam int VEC_ID_W = 5;

endpackage

// File: rtl/intr_req_qualifier.sv
// Debounces int_req: counts consecutive high cycles while qualifying and
// flags a spurious request when int_req drops before it is acknowledged.
module intr_req_qualifier #(
    parameter int REQ_STABLE = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic active_i,
    input  logic int_req_i,
    input  logic cpu_ie_i,
    output logic qual_done_o,
    output logic spurious_o
);

    localparam logic [3:0] LAST = 4'(REQ_STABLE - 1);

    logic [3:0] cnt_q, cnt_d;
    logic       spur_q, spur_d;

    always_comb begin
        cnt_d  = cnt_q;
        spur_d = active_i & ~int_req_i;
        if (start_i) begin
            cnt_d = 4'd0;
        end else if (active_i && int_req_i && cpu_ie_i) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 4'd0;
            spur_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            spur_q <= spur_d;
        end
    end

    // The cycle that completes REQ_STABLE high samples is the one that hands off to ACK.
    assign qual_done_o = active_i & int_req_i & cpu_ie_i & (cnt_q >= LAST);
    assign spurious_o  = spur_q;

endmodule

// File: rtl/intr_ack_sequencer.sv
// Processor-side interrupt acknowledge sequencer: qualifies int_req, runs the
// ack/vector-read handshake, tracks service until eoi and shares the read path
// with software status reads.
module intr_ack_sequencer
    import intr_pkg::*;
#(
    parameter int REQ_STABLE  = 2,
    parameter int VEC_LAT     = 1,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_req,
    input  logic [31:0] data_bus,
    input  logic        cpu_ie,
    input  logic        eoi,
    input  logic        sw_rd_req,
    input  logic [1:0]  sw_sel,
    output logic        int_ack,
    output logic        read,
    output logic [1:0]  s,
    output logic        vec_valid,
    output logic [31:0] vector,
    output logic        in_service,
    output logic [31:0] sw_rd_data,
    output logic        sw_rd_valid,
    output logic        spurious,
    output logic        svc_timeout,
    output logic [15:0] svc_count
);

    localparam int              TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]   TO_MAX   = TW'(ACK_TIMEOUT);
    localparam logic [TW-1:0]   TO_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [2:0]      LAT_LAST = 3'(VEC_LAT - 1);

    state_e        state_q, state_d;
    logic [2:0]    lat_q, lat_d;
    logic [TW-1:0] cyc_q, cyc_d;
    logic [31:0]   vector_q, vector_d;
    logic [31:0]   swdata_q, swdata_d;
    logic [15:0]   count_q, count_d;
    logic          vv_q, vv_d;
    logic          insvc_q, insvc_d;
    logic          swvld_q, swvld_d;
    logic          tmo_q, tmo_d;
    logic          qual_start, qual_done;

    intr_req_qualifier #(.REQ_STABLE(REQ_STABLE)) u_qual (
        .clk_i       (clk),
        .rst_ni      (reset),
        .start_i     (qual_start),
        .active_i    (state_q == ST_QUAL),
        .int_req_i   (int_req),
        .cpu_ie_i    (cpu_ie),
        .qual_done_o (qual_done),
        .spurious_o  (spurious)
    );

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        cyc_d      = cyc_q;
        vector_d   = vector_q;
        swdata_d   = swdata_q;
        count_d    = count_q;
        vv_d       = 1'b0;
        swvld_d    = 1'b0;
        insvc_d    = insvc_q;
        tmo_d      = tmo_q;
        qual_start = 1'b0;
        int_ack    = 1'b0;
        read       = 1'b0;
        s          = SEL_VEC;
        unique case (state_q)
            ST_IDLE: begin
                // The requester sees sw_rd_valid this cycle and is still dropping its request.
                if (sw_rd_req && !swvld_q) begin
                    state_d = ST_SWRD;
                end else if (int_req && cpu_ie) begin
                    state_d    = ST_QUAL;
                    qual_start = 1'b1;
                end
            end
            ST_QUAL: begin
                if (!int_req || !cpu_ie) state_d = ST_IDLE;
                else if (qual_done)      state_d = ST_ACK;
            end
            ST_ACK: begin
                int_ack = 1'b1;
                lat_d   = 3'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                read = 1'b1;
                if (lat_q >= LAT_LAST) state_d = ST_CAPT;
                else                   lat_d   = lat_q + 3'd1;
            end
            ST_CAPT: begin
                read     = 1'b1;
                vector_d = data_bus;
                vv_d     = 1'b1;
                insvc_d  = 1'b1;
                count_d  = count_q + 16'd1;
                cyc_d    = '0;
                state_d  = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (eoi) begin
                    insvc_d = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    if (cyc_q != TO_MAX)  cyc_d = cyc_q + 1'b1;
                    if (cyc_q >= TO_LAST) tmo_d = 1'b1;
                end
            end
            ST_SWRD: begin
                read     = 1'b1;
                s        = sw_sel;
                swdata_d = data_bus;
                swvld_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            lat_q    <= 3'd0;
            cyc_q    <= '0;
            vector_q <= 32'd0;
            swdata_q <= 32'd0;
            count_q  <= 16'd0;
            vv_q     <= 1'b0;
            insvc_q  <= 1'b0;
            swvld_q  <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lat_q    <= lat_d;
            cyc_q    <= cyc_d;
            vector_q <= vector_d;
            swdata_q <= swdata_d;
            count_q  <= count_d;
            vv_q     <= vv_d;
            insvc_q  <= insvc_d;
            swvld_q  <= swvld_d;
            tmo_q    <= tmo_d;
        end
    end

    assign vec_valid   = vv_q;
    assign vector      = vector_q;
    assign in_service  = insvc_q;
    assign sw_rd_data  = swdata_q;
    assign sw_rd_valid = swvld_q;
    assign svc_timeout = tmo_q;
    assign svc_count   = count_q;

endmodule

// File: tb/tb_intr_ack_sequencer.sv
// Bench for intr_ack_sequencer: a small controller model drives data_bus, a
// monitor tracks expected vectors/count, and directed scenarios pin latencies.
module tb_intr_ack_sequencer;
    import intr_pkg::*;

    logic        clk;
    logic        reset;
    logic        int_req;
    logic [31:0] data_bus;
    logic        cpu_ie;
    logic        eoi;
    logic        sw_rd_req;
    logic [1:0]  sw_sel;
    logic        int_ack;
    logic        read;
    logic [1:0]  s;
    logic        vec_valid;
    logic [31:0] vector;
    logic        in_service;
    logic [31:0] sw_rd_data;
    logic        sw_rd_valid;
    logic        spurious;
    logic        svc_timeout;
    logic [15:0] svc_count;

    logic [31:0] irr;
    int          n_chk;
    int          n_fail;
    logic        done;

    // Expected capture order and software-read data over the whole run.
    int          exp_vec[$];
    logic [31:0] exp_sw[$];

    intr_ack_sequencer #(.REQ_STABLE(2), .VEC_LAT(1), .ACK_TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .int_req    (int_req),
        .data_bus   (data_bus),
        .cpu_ie     (cpu_ie),
        .eoi        (eoi),
        .sw_rd_req  (sw_rd_req),
        .sw_sel     (sw_sel),
        .int_ack    (int_ack),
        .read       (read),
        .s          (s),
        .vec_valid  (vec_valid),
        .vector     (vector),
        .in_service (in_service),
        .sw_rd_data (sw_rd_data),
        .sw_rd_valid(sw_rd_valid),
        .spurious   (spurious),
        .svc_timeout(svc_timeout),
        .svc_count  (svc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] top_id(input logic [31:0] v);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) if (v[i]) r = 32'(i);
        return r;
    endfunction

    // Controller side: highest pending source wins the vector read.
    assign int_req = |irr;
    always_comb begin
        data_bus = 32'd0;
        case (s)
            SEL_VEC: data_bus = top_id(irr);
            SEL_IRR: data_bus = irr;
            SEL_IMR: data_bus = 32'hFFFF_FFF7;
            default: data_bus = 32'h0000_0020;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // which: 0 = int_ack, 1 = vec_valid, 2 = sw_rd_valid
    task automatic wait_sig(input int which, input int budget, output int n);
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (which)
                0:       hit = int_ack;
                1:       hit = vec_valid;
                default: hit = sw_rd_valid;
            endcase
        end
        if (!hit) chk($sformatf("wait_timeout_%0d", which), 32'd0, 32'd1);
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        @(negedge clk);
        eoi = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic monitor();
        int          vi;
        int          si;
        logic [15:0] m_cnt;
        logic [31:0] m_vec;
        vi    = 0;
        si    = 0;
        m_cnt = 16'd0;
        m_vec = 32'd0;
        while (!done) begin
            @(negedge clk);
            if (!reset) begin
                m_cnt = 16'd0;
                m_vec = 32'd0;
            end else begin
                if (vec_valid) begin
                    m_cnt = m_cnt + 16'd1;
                    m_vec = (vi < exp_vec.size()) ? 32'(exp_vec[vi]) : 32'hFFFF_FFFF;
                    vi++;
                    chk("mon_insvc_at_vv", {31'd0, in_service}, 32'd1);
                    irr[vector[VEC_ID_W-1:0]] = 1'b0;
                end
                if (sw_rd_valid) begin
                    chk("mon_sw_data", sw_rd_data, (si < exp_sw.size()) ? exp_sw[si] : 32'hDEAD_BEEF);
                    si++;
                end
                chk("mon_vector", vector, m_vec);
                chk("mon_svc_count", {16'd0, svc_count}, {16'd0, m_cnt});
                chk("mon_ack_excl", {31'd0, int_ack & (read | in_service | spurious)}, 32'd0);
            end
        end
    endtask

    task automatic run_tests();
        int n;
        int nsp, nack, nrd, nvld;
        logic [31:0] ids[8];
        ids = '{32'd13, 32'd10, 32'd9, 32'd7, 32'd6, 32'd2, 32'd1, 32'd0};

        // Reset state.
        #1;
        chk("rst_int_ack", {31'd0, int_ack}, 32'd0);
        chk("rst_read", {31'd0, read}, 32'd0);
        chk("rst_s", {30'd0, s}, 32'd0);
        chk("rst_vector", vector, 32'd0);
        chk("rst_svc_count", {16'd0, svc_count}, 32'd0);
        chk("rst_flags", {27'd0, vec_valid, in_service, sw_rd_valid, spurious, svc_timeout}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Source 31 full handshake.
        irr[31] = 1'b1;
        wait_sig(0, 20, n);
        chk("t1_ack_latency", 32'(n), 32'd3);
        wait_sig(1, 20, n);
        chk("t1_vv_latency", 32'(n), 32'd3);
        chk("t1_vector_id", {27'd0, vector[VEC_ID_W-1:0]}, 32'd31);
        chk("t1_in_service", {31'd0, in_service}, 32'd1);
        chk("t1_svc_count", {16'd0, svc_count}, 32'd1);
        pulse_eoi();
        chk("t1_eoi_clears", {31'd0, in_service}, 32'd0);

        // One-cycle request: spurious, no ack.
        irr[20] = 1'b1;
        nsp = 0; nack = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) irr[20] = 1'b0;
            nsp  += int'(spurious);
            nack += int'(int_ack);
        end
        chk("t2_spurious_pulses", 32'(nsp), 32'd1);
        chk("t2_no_ack", 32'(nack), 32'd0);
        chk("t2_idle_no_read", {31'd0, read}, 32'd0);

        // Timeout on source 14, then priority drain.
        do_reset();
        irr = 32'h0000_66C7;
        wait_sig(1, 20, n);
        chk("t3_vector_id14", {27'd0, vector[VEC_ID_W-1:0]}, 32'd14);
        repeat (15) @(negedge clk);
        chk("t3_no_timeout_yet", {31'd0, svc_timeout}, 32'd0);
        @(negedge clk);
        chk("t3_timeout_set", {31'd0, svc_timeout}, 32'd1);
        repeat (3) @(negedge clk);
        chk("t3_timeout_sticky", {31'd0, svc_timeout}, 32'd1);
        pulse_eoi();
        chk("t3_eoi_insvc", {31'd0, in_service}, 32'd0);
        chk("t3_eoi_timeout", {31'd0, svc_timeout}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            wait_sig(1, 20, n);
            chk($sformatf("t3_order_%0d", k), {27'd0, vector[VEC_ID_W-1:0]}, ids[k]);
            pulse_eoi();
        end
        chk("t3_svc_count9", {16'd0, svc_count}, 32'd9);

        // Software IMR read deferred until eoi, then pending source 3.
        do_reset();
        irr = 32'h0000_0028;
        wait_sig(1, 20, n);
        chk("t4_vector_id5", {27'd0, vector[VEC_ID_W-1:0]}, 32'd5);
        sw_rd_req = 1'b1;
        sw_sel    = SEL_IMR;
        nrd = 0; nvld = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nrd  += int'(read && s == SEL_IMR);
            nvld += int'(sw_rd_valid);
        end
        chk("t4_no_read_in_service", 32'(nrd + nvld), 32'd0);
        pulse_eoi();
        nrd = 0; nack = 0; n = 0;
        while (sw_rd_req && n < 10) begin
            @(negedge clk);
            n++;
            nrd  += int'(read && s == SEL_IMR);
            nack += int'(int_ack);
            if (sw_rd_valid) begin
                chk("t4_sw_data", sw_rd_data, 32'hFFFF_FFF7);
                sw_rd_req = 1'b0;
            end
        end
        chk("t4_sw_served", {31'd0, sw_rd_req}, 32'd0);
        chk("t4_sel_one_cycle", 32'(nrd), 32'd1);
        chk("t4_no_ack_before_sw", 32'(nack), 32'd0);
        wait_sig(0, 10, n);
        wait_sig(1, 10, n);
        chk("t4_vector_id3", {27'd0, vector[VEC_ID_W-1:0]}, 32'd3);
        pulse_eoi();

        // Reset during WAIT.
        irr[9] = 1'b1;
        wait_sig(0, 20, n);
        chk("t5_ack_latency", 32'(n), 32'd3);
        @(negedge clk);
        chk("t5_in_wait_read", {31'd0, read}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_ack", {31'd0, int_ack}, 32'd0);
        chk("t5_async_read", {31'd0, read}, 32'd0);
        chk("t5_async_insvc", {31'd0, in_service}, 32'd0);
        chk("t5_async_vector", vector, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_sig(0, 20, n);
        chk("t5_ack_after_reset", 32'(n), 32'd3);
        wait_sig(1, 20, n);
        chk("t5_vv_after_reset", 32'(n), 32'd3);
        chk("t5_vector_id9", {27'd0, vector[VEC_ID_W-1:0]}, 32'd9);
        chk("t5_svc_count", {16'd0, svc_count}, 32'd1);
        pulse_eoi();

        // Interrupts masked by cpu_ie.
        cpu_ie  = 1'b0;
        irr[12] = 1'b1;
        nack = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nack += int'(int_ack | read);
        end
        chk("t6_masked", 32'(nack), 32'd0);
        cpu_ie = 1'b1;
        wait_sig(0, 20, n);
        chk("t6_ack_latency", 32'(n), 32'd3);
        wait_sig(1, 20, n);
        chk("t6_vector_id12", {27'd0, vector[VEC_ID_W-1:0]}, 32'd12);
        chk("t6_svc_count", {16'd0, svc_count}, 32'd2);
        pulse_eoi();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        done      = 1'b0;
        reset     = 1'b0;
        irr       = 32'd0;
        cpu_ie    = 1'b1;
        eoi       = 1'b0;
        sw_rd_req = 1'b0;
        sw_sel    = 2'b00;
        exp_vec   = '{31, 14, 13, 10, 9, 7, 6, 2, 1, 0, 5, 3, 9, 12};
        exp_sw    = '{32'hFFFF_FFF7};
        fork
            begin
                run_tests();
                done = 1'b1;
            end
            monitor();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/intr_ack_sequencer.md
Name: intr_ack_sequencer

Overview:
Processor-side counterpart of the 32-source fixed-priority interrupt controller. It watches int_req, runs the acknowledge handshake (int_ack pulse, then a vector read over data_bus with select lines s), and presents the captured vector to the core. It holds off further acknowledges until the core signals end of service. It also arbitrates software status-register reads onto the same read/s/data_bus path.

Parameters:
REQ_STABLE, 2, consecutive cycles int_req must be high before acknowledge (1..15)
VEC_LAT, 1, cycles from int_ack deassertion to data_bus sample (1..7)
ACK_TIMEOUT, 16, max cycles in SERVICE before a timeout flag is raised (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
int_req  in  1  interrupt request from controller
data_bus  in  32  vector/status data from controller
cpu_ie  in  1  core global interrupt enable
eoi  in  1  end-of-interrupt pulse from core handler
sw_rd_req  in  1  software status read request (level, held until sw_rd_valid)
sw_sel  in  2  register select for software read
int_ack  out  1  acknowledge to controller, one-cycle pulse
read  out  1  read strobe to controller
s  out  2  register select to controller
vec_valid  out  1  one-cycle pulse, vector captured
vector  out  32  last captured vector; [4:0] = source id
in_service  out  1  high from capture until eoi
sw_rd_data  out  32  software read data
sw_rd_valid  out  1  one-cycle pulse, sw_rd_data valid
spurious  out  1  one-cycle pulse, int_req dropped before ack
svc_timeout  out  1  sticky until eoi, SERVICE exceeded ACK_TIMEOUT
svc_count  out  16  serviced-interrupt counter, wraps 0xFFFF->0

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0, s=2'b00, vector=0, svc_count=0.
- States: IDLE, QUAL, ACK, WAIT, CAPT, SERVICE, SWRD.
- IDLE:
  - sw_rd_req=1 -> SWRD. Software reads win only in IDLE.
  - else int_req & cpu_ie -> QUAL, with the qualify counter cleared.
- QUAL: count cycles with int_req=1.
  - int_req=0 -> IDLE with spurious=1 for one cycle.
  - cpu_ie dropping -> IDLE, no spurious.
  - Count reaches REQ_STABLE -> ACK.
- ACK: int_ack=1 for exactly one cycle -> WAIT, with the latency counter cleared.
- WAIT: read=1, s=2'b00 (vector register). After VEC_LAT cycles -> CAPT.
- CAPT: read=1, s=2'b00.
  - vector <= data_bus on this cycle's edge.
  - vec_valid=1 the next cycle; in_service=1 from the next cycle.
  - svc_count+1 -> SERVICE.
- SERVICE:
  - int_req is ignored (nested interrupts are not supported).
  - Cycle counter saturates. At ACK_TIMEOUT, svc_timeout<=1.
  - eoi=1 -> IDLE. in_service and svc_timeout clear the next cycle.
  - If int_req is still high on return to IDLE, a fresh QUAL starts (the controller has already retired the served source; the next source re-arbitrates).
- SWRD: read=1, s=sw_sel for one cycle.
  - sw_rd_data<=data_bus; sw_rd_valid=1 the next cycle -> IDLE.
- eoi outside SERVICE is ignored.
- sw_rd_req arriving outside IDLE is held pending and served on the next IDLE cycle. It is served before a new int_req.
- Simultaneous sw_rd_req and int_req in IDLE: SWRD first, then QUAL.
- Reset mid-handshake aborts immediately. int_ack and read drop asynchronously.
- Latency: int_req rise to int_ack = REQ_STABLE+1 cycles (defaults: 3). int_ack to vec_valid = VEC_LAT+2 cycles.

Decomposition:
- Package intr_pkg holds:
  - state enum encoding
  - select constants: SEL_VEC=2'b00, SEL_IRR=2'b01, SEL_IMR=2'b10, SEL_ISR=2'b11
  - VEC_ID_W=5
- One natural sub-module, intr_req_qualifier: the REQ_STABLE counter plus the spurious detect.

Test Plan:
- irq source 31 asserted, cpu_ie=1, defaults: int_ack pulses 3 cycles after int_req rises. vec_valid follows 3 cycles after int_ack. vector[4:0]=31, in_service=1, svc_count=1.
- int_req high for 1 cycle only: spurious pulses once, no int_ack, state back in IDLE.
- Service source 14, withhold eoi for 16 cycles: svc_timeout=1 and sticky. eoi clears in_service and svc_timeout, then sources 13, 10, 9, 7, 6, 2, 1, 0 are serviced in that order with svc_count=9 after all.
- sw_rd_req with sw_sel=2'b10 during SERVICE: no read until eoi. Then s=2'b10 for one cycle, sw_rd_valid pulses with the IMR value (0xFFFFFFF7). A pending int_req is acknowledged afterward.
- Assert reset in WAIT: int_ack, read, in_service and vector go to 0 at once. After release, a new int_req goes through the full handshake.
- cpu_ie=0 with int_req high: no int_ack. Raising cpu_ie starts QUAL and ack follows REQ_STABLE+1 cycles later.
